// File: rtl/sram_bus_arbiter_if.sv
// Bus bundle between the two pipeline requesters (inst_*, data_*), the
// arbiter, and the shared SRAM-like memory port (mem_*).
// Handshake: a request is a valid/ready pair. The requester holds *_req with
// stable address/control until the matching *_addr_ok is seen high in the
// same cycle; that cycle is the transfer. *_data_ok is a one-cycle pulse with
// read data valid in the same cycle, and responses return in issue order.
interface sram_bus_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  // Arbiter view.
  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  // Environment view: pipeline requesters plus the memory port.
  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like port between fetch (inst) and
// mem-stage (data) requesters. One address handshake per cycle, grant locked
// until accepted, owner of each accepted request kept in an in-order tag FIFO
// so every mem_data_ok is routed back to its issuer.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate the grant when both
// masters request together; otherwise data has fixed priority over inst.
// dbg_hold exposes the lock state (1 = HOLD).
module sram_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk,
  input  logic               reset,
  sram_bus_arbiter_if.slave  bus,
  output logic               dbg_hold
);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PW:0] FULL_CNT = MAX_OUTSTANDING[PW:0];

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} lock_t;

  lock_t                      lock_q;
  logic                       grant_q;   // held owner: 1 = data, 0 = inst
  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [PW:0]                count_q;

  logic grant;       // 1 = data master owns the port this cycle
  logic mem_req_c;
  logic both_pick;   // winner when both request while unlocked
  logic full;
  logic push;
  logic pop;
  logic head_tag;

  assign full     = (count_q == FULL_CNT);
  assign head_tag = tag_q[rd_ptr];
  assign dbg_hold = (lock_q == HOLD);

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last_q;   // owner of the most recently accepted address
  assign both_pick = ~rr_last_q;

  // Remember who was served last so a tie goes to the other master.
  always_ff @(posedge clk) begin
    if (reset)     rr_last_q <= 1'b0;
    else if (push) rr_last_q <= grant;
  end
`else
  assign both_pick = 1'b1;
`endif

  // Pick the owner: a held grant wins outright, otherwise arbitrate if there is FIFO room.
  always_comb begin
    grant     = 1'b0;
    mem_req_c = 1'b0;
    if (lock_q == HOLD) begin
      grant     = grant_q;
      mem_req_c = grant_q ? bus.data_req : bus.inst_req;
    end else if (!full) begin
      if (bus.data_req && bus.inst_req) grant = both_pick;
      else                              grant = bus.data_req;
      mem_req_c = bus.data_req | bus.inst_req;
    end
    if (reset) mem_req_c = 1'b0;
  end

  assign push = mem_req_c & bus.mem_addr_ok;
  // A response with nothing outstanding is stale (e.g. issued before a reset) and is dropped.
  assign pop  = bus.mem_data_ok & (count_q != '0) & ~reset;

  assign bus.mem_req      = mem_req_c;
  assign bus.inst_addr_ok = push & ~grant;
  assign bus.data_addr_ok = push & grant;
  assign bus.inst_data_ok = pop & ~head_tag;
  assign bus.data_data_ok = pop & head_tag;
  assign bus.inst_rdata   = reset ? 32'd0 : bus.mem_rdata;
  assign bus.data_rdata   = reset ? 32'd0 : bus.mem_rdata;

  // Route the granted master's address/control; fetches are always word reads.
  always_comb begin
    bus.mem_wr    = 1'b0;
    bus.mem_size  = 2'd0;
    bus.mem_wstrb = 4'd0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    if (!reset) begin
      if (grant) begin
        bus.mem_wr    = bus.data_wr;
        bus.mem_size  = bus.data_size;
        bus.mem_wstrb = bus.data_wstrb;
        bus.mem_addr  = bus.data_addr;
        bus.mem_wdata = bus.data_wdata;
      end else begin
        bus.mem_size  = 2'd2;
        bus.mem_addr  = bus.inst_addr;
      end
    end
  end

  // Lock FSM: freeze the grant while a request waits for mem_addr_ok; release on accept or flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q  <= IDLE;
      grant_q <= 1'b0;
    end else begin
      case (lock_q)
        IDLE: begin
          if (mem_req_c && !bus.mem_addr_ok) begin
            lock_q  <= HOLD;
            grant_q <= grant;
          end
        end
        HOLD: begin
          if (!mem_req_c || bus.mem_addr_ok) lock_q <= IDLE;
        end
        default: lock_q <= IDLE;
      endcase
    end
  end

  // Owner tag FIFO: push on address accept, pop on response; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr] <= grant;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Testbench for sram_bus_arbiter: directed scenarios plus a randomized run
// checked against a queue-based owner model.
module tb_sram_bus_arbiter;
  localparam int MAX = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic reset;
  logic dbg_hold;
  int   n_cmp;
  int   n_err;

  sram_bus_arbiter_if bus ();

  sram_bus_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .dbg_hold (dbg_hold)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.inst_req    = 1'b0;
    bus.inst_addr   = 32'd0;
    bus.data_req    = 1'b0;
    bus.data_wr     = 1'b0;
    bus.data_size   = 2'd0;
    bus.data_wstrb  = 4'd0;
    bus.data_addr   = 32'd0;
    bus.data_wdata  = 32'd0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    bus.inst_req = 1'b1; bus.data_req = 1'b1; bus.inst_addr = 32'h1234_5678;
    bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hdead_beef;
    #1;
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %b exp 0", bus.mem_req); end
    n_cmp++; if ({bus.inst_addr_ok, bus.data_addr_ok} !== 2'b00) begin n_err++; $display("FAIL rst_addr_ok: got %b exp 00", {bus.inst_addr_ok, bus.data_addr_ok}); end
    n_cmp++; if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b00) begin n_err++; $display("FAIL rst_data_ok: got %b exp 00", {bus.inst_data_ok, bus.data_data_ok}); end
    n_cmp++; if (bus.mem_addr !== 32'd0 || bus.inst_rdata !== 32'd0) begin n_err++; $display("FAIL rst_bus_zero: got addr %h rdata %h exp 0", bus.mem_addr, bus.inst_rdata); end
    tick();
    tick();
    reset = 1'b0;
    drive_idle();
    #1;
    n_cmp++; if ({dbg_hold, bus.mem_req} !== 2'b00) begin n_err++; $display("FAIL post_rst_idle: got %b exp 00", {dbg_hold, bus.mem_req}); end
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h5555_aaaa;
    #1;
    n_cmp++; if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b00) begin n_err++; $display("FAIL empty_data_ok: got %b exp 00", {bus.inst_data_ok, bus.data_data_ok}); end
    tick();
    drive_idle();
  endtask

  task automatic test_inst_read();
    do_reset();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1c00_0000; bus.mem_addr_ok = 1'b1;
    #1;
    n_cmp++; if (bus.inst_addr_ok !== 1'b1 || bus.mem_req !== 1'b1) begin n_err++; $display("FAIL inst_addr_ok: got %b/%b exp 1/1", bus.inst_addr_ok, bus.mem_req); end
    n_cmp++; if ({bus.mem_wr, bus.mem_size, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata} !== {1'b0, 2'd2, 4'd0, 32'h1c00_0000, 32'd0})
      begin n_err++; $display("FAIL inst_mux: got wr %b sz %0d st %h a %h wd %h", bus.mem_wr, bus.mem_size, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata); end
    tick();
    drive_idle();
    #1;
    n_cmp++; if (bus.inst_data_ok !== 1'b0) begin n_err++; $display("FAIL inst_early_data_ok: got %b exp 0", bus.inst_data_ok); end
    tick();
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0280_0c0c;
    #1;
    n_cmp++; if (bus.inst_data_ok !== 1'b1 || bus.data_data_ok !== 1'b0) begin n_err++; $display("FAIL inst_data_ok: got %b%b exp 10", bus.inst_data_ok, bus.data_data_ok); end
    n_cmp++; if (bus.inst_rdata !== 32'h0280_0c0c) begin n_err++; $display("FAIL inst_rdata: got %h exp 02800c0c", bus.inst_rdata); end
    tick();
    drive_idle();
  endtask

  task automatic test_priority();
    logic       exp_b;
    logic [0:0] tags [3];
    do_reset();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_1000;
    bus.data_req = 1'b1; bus.data_addr = 32'h8000_0040; bus.data_wr = 1'b1;
    bus.data_size = 2'd2; bus.data_wstrb = 4'hf; bus.data_wdata = 32'hcafe_f00d;
    bus.mem_addr_ok = 1'b1;
    #1;
    n_cmp++; if ({bus.data_addr_ok, bus.inst_addr_ok} !== 2'b10) begin n_err++; $display("FAIL prio_tie1: got d/i %b exp 10", {bus.data_addr_ok, bus.inst_addr_ok}); end
    n_cmp++; if ({bus.mem_wr, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata} !== {1'b1, 4'hf, 32'h8000_0040, 32'hcafe_f00d})
      begin n_err++; $display("FAIL prio_data_mux: got wr %b st %h a %h wd %h", bus.mem_wr, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata); end
    tick();
    // Tie again after data was served: fixed priority keeps data, round-robin turns to inst.
    exp_b = ~RR;
    bus.data_addr = 32'h8000_0044; bus.data_wr = 1'b0;
    #1;
    n_cmp++; if ({bus.data_addr_ok, bus.inst_addr_ok} !== {exp_b, ~exp_b}) begin n_err++; $display("FAIL prio_tie2: got d/i %b exp %b", {bus.data_addr_ok, bus.inst_addr_ok}, {exp_b, ~exp_b}); end
    tick();
    bus.data_req = ~exp_b; bus.inst_req = exp_b;
    #1;
    n_cmp++; if ({bus.data_addr_ok, bus.inst_addr_ok} !== {~exp_b, exp_b}) begin n_err++; $display("FAIL prio_loser: got d/i %b exp %b", {bus.data_addr_ok, bus.inst_addr_ok}, {~exp_b, exp_b}); end
    tick();
    drive_idle();
    tags[0] = 1'b1; tags[1] = exp_b; tags[2] = ~exp_b;
    for (int k = 0; k < 3; k++) begin
      bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h1000 + k;
      #1;
      n_cmp++; if ({bus.data_data_ok, bus.inst_data_ok} !== {tags[k], ~tags[k]}) begin n_err++; $display("FAIL prio_resp%0d: got d/i %b exp %b", k, {bus.data_data_ok, bus.inst_data_ok}, {tags[k], ~tags[k]}); end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_hold();
    do_reset();
    bus.data_req = 1'b1; bus.data_addr = 32'h0000_a0a0; bus.data_size = 2'd1;
    #1;
    n_cmp++; if ({bus.mem_req, bus.data_addr_ok, dbg_hold} !== 3'b100) begin n_err++; $display("FAIL hold_start: got %b exp 100", {bus.mem_req, bus.data_addr_ok, dbg_hold}); end
    tick();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_b0b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_cmp++; if ({bus.mem_addr, bus.inst_addr_ok, dbg_hold} !== {32'h0000_a0a0, 1'b0, 1'b1})
        begin n_err++; $display("FAIL hold_c%0d: got a %h iok %b h %b exp a0a0/0/1", c, bus.mem_addr, bus.inst_addr_ok, dbg_hold); end
      tick();
    end
    bus.mem_addr_ok = 1'b1;
    #1;
    n_cmp++; if ({bus.data_addr_ok, bus.inst_addr_ok, bus.mem_addr} !== {2'b10, 32'h0000_a0a0}) begin n_err++; $display("FAIL hold_accept: got %b %h exp 10 a0a0", {bus.data_addr_ok, bus.inst_addr_ok}, bus.mem_addr); end
    tick();
    bus.data_req = 1'b0;
    #1;
    n_cmp++; if ({bus.inst_addr_ok, dbg_hold, bus.mem_addr} !== {2'b10, 32'h0000_b0b0}) begin n_err++; $display("FAIL hold_next_inst: got %b %h exp 10 b0b0", {bus.inst_addr_ok, dbg_hold}, bus.mem_addr); end
    tick();
    // Flush: held data request withdrawn; inst must wait until the lock is released.
    bus.inst_req = 1'b0; bus.data_req = 1'b1; bus.mem_addr_ok = 1'b0;
    tick();
    bus.inst_req = 1'b1; bus.data_req = 1'b0; bus.mem_addr_ok = 1'b1;
    #1;
    n_cmp++; if ({bus.mem_req, bus.inst_addr_ok, dbg_hold} !== 3'b001) begin n_err++; $display("FAIL flush_block: got %b exp 001", {bus.mem_req, bus.inst_addr_ok, dbg_hold}); end
    tick();
    #1;
    n_cmp++; if ({bus.inst_addr_ok, dbg_hold} !== 2'b10) begin n_err++; $display("FAIL flush_release: got %b exp 10", {bus.inst_addr_ok, dbg_hold}); end
    tick();
    drive_idle();
  endtask

  task automatic test_full();
    do_reset();
    bus.inst_req = 1'b1; bus.mem_addr_ok = 1'b1;
    for (int k = 0; k < MAX; k++) begin
      bus.inst_addr = 32'h100 + 4 * k;
      #1;
      n_cmp++; if (bus.inst_addr_ok !== 1'b1) begin n_err++; $display("FAIL fill_%0d: got %b exp 1", k, bus.inst_addr_ok); end
      tick();
    end
    bus.inst_addr = 32'h200; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h7777_0000;
    #1;
    n_cmp++; if ({bus.mem_req, bus.inst_addr_ok, bus.inst_data_ok} !== 3'b001) begin n_err++; $display("FAIL full_block: got %b exp 001", {bus.mem_req, bus.inst_addr_ok, bus.inst_data_ok}); end
    tick();
    bus.mem_data_ok = 1'b0;
    #1;
    n_cmp++; if ({bus.mem_req, bus.inst_addr_ok} !== 2'b11) begin n_err++; $display("FAIL full_retry: got %b exp 11", {bus.mem_req, bus.inst_addr_ok}); end
    tick();
    #1;
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL full_again: got %b exp 0", bus.mem_req); end
    drive_idle();
    tick();
  endtask

  task automatic test_order_reset();
    logic [0:0] seq [3];
    seq[0] = 1'b0; seq[1] = 1'b1; seq[2] = 1'b0;
    do_reset();
    bus.mem_addr_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.inst_req = ~seq[k]; bus.data_req = seq[k]; bus.data_wr = 1'b0;
      tick();
    end
    drive_idle();
    for (int k = 0; k < 3; k++) begin
      bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hab00_0000 + k;
      #1;
      n_cmp++; if ({bus.data_data_ok, bus.inst_data_ok} !== {seq[k], ~seq[k]}) begin n_err++; $display("FAIL order_%0d: got d/i %b exp %b", k, {bus.data_data_ok, bus.inst_data_ok}, {seq[k], ~seq[k]}); end
      n_cmp++; if ((seq[k] ? bus.data_rdata : bus.inst_rdata) !== 32'hab00_0000 + k) begin n_err++; $display("FAIL order_rdata%0d: got %h exp %h", k, seq[k] ? bus.data_rdata : bus.inst_rdata, 32'hab00_0000 + k); end
      tick();
    end
    drive_idle();
    bus.mem_addr_ok = 1'b1; bus.inst_req = 1'b1;
    tick();
    bus.inst_req = 1'b0; bus.data_req = 1'b1;
    tick();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h5a5a_0000 + k;
      #1;
      n_cmp++; if ({bus.data_data_ok, bus.inst_data_ok} !== 2'b00) begin n_err++; $display("FAIL stale_%0d: got %b exp 00", k, {bus.data_data_ok, bus.inst_data_ok}); end
      tick();
    end
    drive_idle();
  endtask

  // Randomized traffic against an owner-queue model: who may own the port is
  // derived from the held owner, the outstanding queue depth and the tie rule.
  task automatic test_random(input int cycles);
    logic [0:0]  exp_q[$];
    int          held;        // -1 none, 0 inst, 1 data
    logic        rr_last;
    logic        g, g_valid, acc, rsp;
    logic [70:0] exp_mux;
    do_reset();
    held = -1; rr_last = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      reset           = ($urandom_range(0, 149) == 0);
      bus.inst_req    = ($urandom_range(0, 3) != 0);
      bus.inst_addr   = $urandom;
      bus.data_req    = ($urandom_range(0, 2) == 0);
      bus.data_wr     = $urandom_range(0, 1);
      bus.data_size   = $urandom_range(0, 2);
      bus.data_wstrb  = $urandom_range(0, 15);
      bus.data_addr   = $urandom;
      bus.data_wdata  = $urandom;
      bus.mem_addr_ok = $urandom_range(0, 1);
      bus.mem_data_ok = ($urandom_range(0, 2) == 0);
      bus.mem_rdata   = $urandom;
      g = 1'b0; g_valid = 1'b0;
      if (held >= 0) begin
        g = (held == 1); g_valid = g ? bus.data_req : bus.inst_req;
      end else if (exp_q.size() < MAX) begin
        if (bus.data_req && bus.inst_req) g = RR ? ~rr_last : 1'b1;
        else g = bus.data_req;
        g_valid = bus.data_req | bus.inst_req;
      end
      if (reset) g_valid = 1'b0;
      acc = g_valid & bus.mem_addr_ok;
      rsp = bus.mem_data_ok & (exp_q.size() > 0) & ~reset;
      exp_mux = g ? {bus.data_wr, bus.data_size, bus.data_wstrb, bus.data_addr, bus.data_wdata}
                  : {1'b0, 2'd2, 4'd0, bus.inst_addr, 32'd0};
      #1;
      n_cmp++; if ({bus.mem_req, bus.inst_addr_ok, bus.data_addr_ok} !== {g_valid, acc & ~g, acc & g})
        begin n_err++; $display("FAIL rnd_grant c%0d: got %b exp %b", c, {bus.mem_req, bus.inst_addr_ok, bus.data_addr_ok}, {g_valid, acc & ~g, acc & g}); end
      if (g_valid) begin
        n_cmp++; if ({bus.mem_wr, bus.mem_size, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata} !== exp_mux)
          begin n_err++; $display("FAIL rnd_mux c%0d: got %h exp %h", c, {bus.mem_wr, bus.mem_size, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata}, exp_mux); end
      end
      n_cmp++; if ({bus.inst_data_ok, bus.data_data_ok} !== {rsp & ~exp_q[0], rsp & exp_q[0]})
        begin n_err++; $display("FAIL rnd_resp c%0d: got %b exp %b", c, {bus.inst_data_ok, bus.data_data_ok}, {rsp & ~exp_q[0], rsp & exp_q[0]}); end
      if (rsp) begin
        n_cmp++; if ((exp_q[0] ? bus.data_rdata : bus.inst_rdata) !== bus.mem_rdata)
          begin n_err++; $display("FAIL rnd_rdata c%0d: got %h exp %h", c, exp_q[0] ? bus.data_rdata : bus.inst_rdata, bus.mem_rdata); end
      end
      if (reset) begin
        exp_q.delete(); held = -1; rr_last = 1'b0;
      end else begin
        if (rsp) void'(exp_q.pop_front());
        if (acc) begin exp_q.push_back(g); rr_last = g; end
        if (held >= 0) begin
          if (!g_valid || bus.mem_addr_ok) held = -1;
        end else if (g_valid && !bus.mem_addr_ok) begin
          held = g ? 1 : 0;
        end
      end
      tick();
    end
    reset = 1'b0;
    drive_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_inst_read();
    test_priority();
    test_hold();
    test_full();
    test_order_reset();
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
